// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_if
//  Description : Handshake/data bundle for sync_fifo.
//                master = producer/consumer side, slave = FIFO side.
//                we/d/re   : write request, write data, pop request
//                q/empty   : head word and its not-valid flag
//                full/almost_full/almost_empty/level : fill reporting
//                overflow/underflow : sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
);
   logic                  we;
   logic [DATA_WIDTH-1:0] d;
   logic                  re;
   logic [DATA_WIDTH-1:0] q;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output we, d, re,
      input  q, empty, full, almost_full, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  we, d, re,
      output q, empty, full, almost_full, almost_empty, level, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FWFT FIFO on one block RAM with a registered
//                output stage. Reports fill level, almost-full/almost-empty
//                thresholds and sticky overflow/underflow.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - sync_fifo_if.slave (we/d/re in; q, flags, level out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 9,
   parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 4,
   parameter int AEMPTY_LEVEL = 4
) (
   input  wire logic  clk,
   input  wire logic  rst,
   sync_fifo_if.slave bus
);

   localparam int                  c_depth      = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_depth_lvl  = (ADDR_WIDTH+1)'(c_depth);
   localparam logic [ADDR_WIDTH:0] c_afull_lvl  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] c_aempty_lvl = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

   // Output-stage states
   localparam logic [1:0] OUT_EMPTY = 2'd0;  // output register holds nothing
   localparam logic [1:0] OUT_FILL  = 2'd1;  // RAM read in flight
   localparam logic [1:0] OUT_VALID = 2'd2;  // output register holds the head

   logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
   logic [DATA_WIDTH-1:0] r_ram_q;
   logic [DATA_WIDTH-1:0] r_q;
   logic [ADDR_WIDTH:0]   r_wptr;
   logic [ADDR_WIDTH:0]   r_rptr;
   logic [ADDR_WIDTH:0]   r_level;
   logic [ADDR_WIDTH:0]   w_level_nxt;
   logic [1:0]            r_state;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic                  w_ram_ne;
   logic                  w_ram_rd;

   assign w_wr_ok  = bus.we & ~r_full;
   assign w_rd_ok  = bus.re & ~r_empty;
   // Pointers before the edge: a word being written this cycle is never
   // read in the same cycle, so the RAM never sees a read/write collision.
   assign w_ram_ne = (r_wptr != r_rptr);
   assign w_ram_rd = w_ram_ne &
                     ((r_state == OUT_EMPTY) | ((r_state == OUT_VALID) & w_rd_ok));

   always_comb begin
      w_level_nxt = r_level;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_level_nxt = r_level + 1'b1;
         2'b01:   w_level_nxt = r_level - 1'b1;
         default: w_level_nxt = r_level;
      endcase
   end

   // Block RAM: write port plus registered read port, no reset on contents.
   always_ff @(posedge clk) begin
      if (w_wr_ok && !rst) begin
         r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.d;
      end
      if (w_ram_rd) begin
         r_ram_q <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
      end
   end

   // Pointers, level and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == c_depth_lvl);
         r_afull  <= (w_level_nxt >= c_afull_lvl);
         r_aempty <= (w_level_nxt <= c_aempty_lvl);
         if (bus.we && r_full) begin
            r_ovf <= 1'b1;
         end
         if (bus.re && r_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   // Prefetch FSM: keeps the output register loaded with the head word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= OUT_EMPTY;
         r_rptr  <= '0;
         r_q     <= '0;
         r_empty <= 1'b1;
      end else begin
         case (r_state)
            OUT_EMPTY: begin
               if (w_ram_ne) begin
                  r_rptr  <= r_rptr + 1'b1;
                  r_state <= OUT_FILL;
               end
            end
            OUT_FILL: begin
               r_q     <= r_ram_q;
               r_empty <= 1'b0;
               r_state <= OUT_VALID;
            end
            OUT_VALID: begin
               // q is left untouched after a pop; empty covers the gap
               // until the next word lands.
               if (w_rd_ok) begin
                  r_empty <= 1'b1;
                  if (w_ram_ne) begin
                     r_rptr  <= r_rptr + 1'b1;
                     r_state <= OUT_FILL;
                  end else begin
                     r_state <= OUT_EMPTY;
                  end
               end
            end
            default: begin
               r_state <= OUT_EMPTY;
               r_empty <= 1'b1;
            end
         endcase
      end
   end

   assign bus.q            = r_q;
   assign bus.empty        = r_empty;
   assign bus.full         = r_full;
   assign bus.almost_full  = r_afull;
   assign bus.almost_empty = r_aempty;
   assign bus.level        = r_level;
   assign bus.overflow     = r_ovf;
   assign bus.underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Directed self-checking bench for sync_fifo
//                (DATA_WIDTH=8, ADDR_WIDTH=8, AFULL=252, AEMPTY=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int AW = 8;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   model [$];

   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sync_fifo #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .AFULL_LEVEL  (252),
      .AEMPTY_LEVEL (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_empty"},  32'(bus.empty), 32'd1);
      chk({tag, "_full"},   32'(bus.full), 32'd0);
      chk({tag, "_afull"},  32'(bus.almost_full), 32'd0);
      chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'd1);
      chk({tag, "_level"},  32'(bus.level), 32'd0);
      chk({tag, "_ovf"},    32'(bus.overflow), 32'd0);
      chk({tag, "_unf"},    32'(bus.underflow), 32'd0);
      chk({tag, "_q"},      32'(bus.q), 32'd0);
   endtask

   // Bounded wait for the head word; an expired bound counts as a failure.
   task automatic wait_nonempty(input string tag);
      int k;
      k = 0;
      while (bus.empty && k < 8) begin
         step();
         k++;
      end
      if (bus.empty) chk({tag, "_timeout"}, 32'(bus.empty), 32'd0);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      wait_nonempty(tag);
      chk({tag, "_q"}, 32'(bus.q), 32'(exp));
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic we_r;
      logic re_r;
      logic [7:0] d_r;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      bus.we  = 1'b0;
      bus.re  = 1'b0;
      bus.d   = '0;
      step();
      step();
      chk_reset("rst0");
      rst = 1'b0;

      // Single word latency
      bus.we = 1'b1; bus.d = 8'hA5;
      step();                                   // E0
      bus.we = 1'b0;
      chk("one_level_e0", 32'(bus.level), 32'd1);
      chk("one_empty_e0", 32'(bus.empty), 32'd1);
      step();                                   // E1
      chk("one_empty_e1", 32'(bus.empty), 32'd1);
      step();                                   // E2
      chk("one_q_e2", 32'(bus.q), 32'hA5);
      chk("one_empty_e2", 32'(bus.empty), 32'd0);
      step();
      chk("one_q_hold", 32'(bus.q), 32'hA5);
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;
      chk("one_level_pop", 32'(bus.level), 32'd0);
      chk("one_empty_pop", 32'(bus.empty), 32'd1);

      // Fill to full, then one more write
      for (int i = 0; i < 256; i++) begin
         bus.we = 1'b1; bus.d = 8'(i);
         step();
         chk("fill_level", 32'(bus.level), 32'(i + 1));
         chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 252));
         chk("fill_full",  32'(bus.full), 32'((i + 1) == 256));
      end
      chk("fill_ovf_before", 32'(bus.overflow), 32'd0);
      bus.d = 8'hEE;
      step();
      bus.we = 1'b0;
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      chk("ovf_level", 32'(bus.level), 32'd256);
      chk("ovf_full", 32'(bus.full), 32'd1);

      // Drain in order
      for (int j = 0; j < 256; j++) begin
         pop_check("drain", 8'(j));
         chk("drain_level", 32'(bus.level), 32'(255 - j));
         chk("drain_aempty", 32'(bus.almost_empty), 32'((255 - j) <= 4));
      end
      step(); step(); step();
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("drain_unf_before", 32'(bus.underflow), 32'd0);
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;
      chk("unf_set", 32'(bus.underflow), 32'd1);
      chk("unf_level", 32'(bus.level), 32'd0);

      // Random traffic against a reference queue
      for (int c = 0; c < 1000; c++) begin
         if (model.size() == 0) chk("rnd_empty", 32'(bus.empty), 32'd1);
         we_r = 1'($urandom_range(0, 1));
         re_r = 1'($urandom_range(0, 1)) & ~bus.empty & (model.size() != 0);
         d_r  = 8'($urandom_range(0, 255));
         if (re_r) chk("rnd_q", 32'(bus.q), 32'(model[0]));
         bus.we = we_r; bus.re = re_r; bus.d = d_r;
         if (we_r && model.size() < 256) model.push_back(int'(d_r));
         if (re_r) void'(model.pop_front());
         step();
         chk("rnd_level", 32'(bus.level), 32'(model.size()));
      end
      bus.we = 1'b0; bus.re = 1'b0;

      // Reset mid-operation with level 100
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bus.we = 1'b1; bus.d = 8'(i + 8'h40);
         step();
      end
      bus.we = 1'b0;
      chk("mid_level100", 32'(bus.level), 32'd100);
      rst = 1'b1; bus.we = 1'b1; bus.d = 8'h99;
      step();
      rst = 1'b0; bus.we = 1'b0;
      chk_reset("midrst");
      bus.we = 1'b1; bus.d = 8'h3C;
      step();
      bus.we = 1'b0;
      step(); step();
      chk("post_rst_q", 32'(bus.q), 32'h3C);
      chk("post_rst_empty", 32'(bus.empty), 32'd0);
      chk("post_rst_level", 32'(bus.level), 32'd1);
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;

      // Full with simultaneous pop and write
      for (int i = 0; i < 256; i++) begin
         bus.we = 1'b1; bus.d = 8'(i);
         step();
      end
      bus.we = 1'b0;
      wait_nonempty("sim");
      chk("sim_full", 32'(bus.full), 32'd1);
      chk("sim_q0", 32'(bus.q), 32'd0);
      bus.we = 1'b1; bus.re = 1'b1; bus.d = 8'h77;
      step();
      bus.we = 1'b0; bus.re = 1'b0;
      chk("sim_level", 32'(bus.level), 32'd255);
      chk("sim_ovf", 32'(bus.overflow), 32'd1);
      chk("sim_full_after", 32'(bus.full), 32'd0);
      for (int j = 1; j < 256; j++) begin
         pop_check("sim_drain", 8'(j));
      end
      step(); step(); step();
      chk("sim_end_empty", 32'(bus.empty), 32'd1);
      chk("sim_end_level", 32'(bus.level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
